// File: rtl/ble_config_loader_pkg.sv
// Shared constants, state encodings and sizing helpers for the BLE configuration loader.
package ble_cfg_pkg;

   localparam int unsigned TIMER_W = 8;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LOAD   = 3'd1;
   localparam state_t ST_SETUP  = 3'd2;
   localparam state_t ST_PULSE  = 3'd3;
   localparam state_t ST_HOLD   = 3'd4;
   localparam state_t ST_FINISH = 3'd5;

   function automatic int unsigned nwords(input int unsigned strobe_size,
                                          input int unsigned data_size);
      return (strobe_size + data_size - 1) / data_size;
   endfunction

   // Number of live cells in the final word; always 1..data_size.
   function automatic int unsigned rem(input int unsigned strobe_size,
                                       input int unsigned data_size);
      return strobe_size - data_size * (nwords(strobe_size, data_size) - 1);
   endfunction

endpackage

// File: rtl/ble_config_loader_if.sv
// Configuration stream plus element-side DATA/STROBE bus of the loader.
interface ble_config_loader_if #(
   parameter int unsigned DATA_SIZE   = 8,
   parameter int unsigned STROBE_SIZE = 17
);

   logic                   START;
   logic [DATA_SIZE-1:0]   CFG_DATA;
   logic                   CFG_VALID;
   logic                   CFG_READY;
   logic [DATA_SIZE-1:0]   DATA;
   logic [STROBE_SIZE-1:0] STROBE;
   logic                   BUSY;
   logic                   DONE;

   modport master (
      output START, CFG_DATA, CFG_VALID,
      input  CFG_READY, DATA, STROBE, BUSY, DONE
   );

   modport slave (
      input  START, CFG_DATA, CFG_VALID,
      output CFG_READY, DATA, STROBE, BUSY, DONE
   );

endinterface

// File: rtl/ble_config_loader_strobe_decode.sv
// Maps a word index to the strobe group it programs; the final group is
// naturally truncated at STROBE_SIZE.
module ble_strobe_decode
   import ble_cfg_pkg::*;
#(
   parameter int unsigned DATA_SIZE   = 8,
   parameter int unsigned STROBE_SIZE = 17,
   parameter int unsigned IDX_W       = 2
) (
   input  logic [IDX_W-1:0]       word_idx,
   output logic [STROBE_SIZE-1:0] mask
);

   always_comb begin
      mask = '0;
      for (int unsigned b = 0; b < STROBE_SIZE; b++) begin
         if ((b / DATA_SIZE) == 32'(word_idx)) mask[b] = 1'b1;
      end
   end

endmodule

// File: rtl/ble_config_loader.sv
// Streams configuration words onto a logic element's shared DATA bus and
// pulses each cell group's STROBE with setup/pulse/hold spacing.
module ble_config_loader
   import ble_cfg_pkg::*;
#(
   parameter int unsigned DATA_SIZE   = 8,
   parameter int unsigned STROBE_SIZE = 17,
   parameter int unsigned SETUP_CYC   = 1,
   parameter int unsigned PULSE_CYC   = 1,
   parameter int unsigned HOLD_CYC    = 1
) (
   input logic CLK,
   input logic RST,
   ble_config_loader_if.slave cfg_if
);

   localparam int unsigned NWORDS = nwords(STROBE_SIZE, DATA_SIZE);
   localparam int unsigned REM    = rem(STROBE_SIZE, DATA_SIZE);
   localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   localparam logic [TIMER_W-1:0] SETUP_LD = TIMER_W'(SETUP_CYC - 1);
   localparam logic [TIMER_W-1:0] PULSE_LD = TIMER_W'(PULSE_CYC - 1);
   localparam logic [TIMER_W-1:0] HOLD_LD  = TIMER_W'(HOLD_CYC - 1);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NWORDS - 1);

   state_t                 state_q,     state_d;
   logic [IDX_W-1:0]       word_idx_q,  word_idx_d;
   logic [TIMER_W-1:0]     timer_q,     timer_d;
   logic [DATA_SIZE-1:0]   data_q,      data_d;
   logic [STROBE_SIZE-1:0] strobe_q,    strobe_d;
   logic                   cfg_ready_q, cfg_ready_d;
   logic                   busy_q,      busy_d;
   logic                   done_q,      done_d;

   logic [STROBE_SIZE-1:0] group_mask;
   logic [DATA_SIZE-1:0]   load_word;
   logic                   last_word;

   ble_strobe_decode #(
      .DATA_SIZE   (DATA_SIZE),
      .STROBE_SIZE (STROBE_SIZE),
      .IDX_W       (IDX_W)
   ) u_decode (
      .word_idx (word_idx_q),
      .mask     (group_mask)
   );

   assign last_word = (word_idx_q == LAST_IDX);

   // Bits beyond the last live cell are cleared so unused DATA lines stay quiet.
   always_comb begin
      load_word = cfg_if.CFG_DATA;
      if (last_word) begin
         for (int unsigned b = 0; b < DATA_SIZE; b++) begin
            if (b >= REM) load_word[b] = 1'b0;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      timer_d    = timer_q;
      data_d     = data_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_if.START) begin
               state_d    = ST_LOAD;
               word_idx_d = '0;
               timer_d    = '0;
            end
         end
         ST_LOAD: begin
            if (cfg_if.CFG_VALID && cfg_ready_q) begin
               data_d  = load_word;
               state_d = ST_SETUP;
               timer_d = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (timer_q == '0) begin
               state_d = ST_PULSE;
               timer_d = PULSE_LD;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_PULSE: begin
            if (timer_q == '0) begin
               state_d = ST_HOLD;
               timer_d = HOLD_LD;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_HOLD: begin
            if (timer_q == '0) begin
               if (last_word) begin
                  state_d = ST_FINISH;
               end else begin
                  word_idx_d = word_idx_q + IDX_W'(1);
                  state_d    = ST_LOAD;
               end
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_FINISH: begin
            data_d  = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with state_q.
      cfg_ready_d = (state_d == ST_LOAD);
      busy_d      = (state_d != ST_IDLE);
      strobe_d    = (state_d == ST_PULSE) ? group_mask : '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         word_idx_q  <= '0;
         timer_q     <= '0;
         data_q      <= '0;
         strobe_q    <= '0;
         cfg_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_idx_q  <= word_idx_d;
         timer_q     <= timer_d;
         data_q      <= data_d;
         strobe_q    <= strobe_d;
         cfg_ready_q <= cfg_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign cfg_if.CFG_READY = cfg_ready_q;
   assign cfg_if.DATA      = data_q;
   assign cfg_if.STROBE    = strobe_q;
   assign cfg_if.BUSY      = busy_q;
   assign cfg_if.DONE      = done_q;

endmodule

// File: tb/tb_ble_config_loader.sv
// Directed bench for ble_config_loader: default timing, stretched timing and
// a whole-word (16-cell) element, each with its own instance.
module tb_ble_config_loader;

   logic clk;
   logic [2:0] rst_v;
   logic [2:0] start_v;
   logic [2:0] valid_v;
   logic [7:0] cfg_v [3];

   logic [31:0] o_data   [3];
   logic [31:0] o_strobe [3];
   logic [31:0] o_ready  [3];
   logic [31:0] o_busy   [3];
   logic [31:0] o_done   [3];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt_a = 0;
   int h0, h1, h2, dc;

   ble_config_loader_if #(.DATA_SIZE(8), .STROBE_SIZE(17)) if_a ();
   ble_config_loader_if #(.DATA_SIZE(8), .STROBE_SIZE(17)) if_b ();
   ble_config_loader_if #(.DATA_SIZE(8), .STROBE_SIZE(16)) if_c ();

   ble_config_loader #(.DATA_SIZE(8), .STROBE_SIZE(17), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1))
      u_a (.CLK(clk), .RST(rst_v[0]), .cfg_if(if_a));
   ble_config_loader #(.DATA_SIZE(8), .STROBE_SIZE(17), .SETUP_CYC(3), .PULSE_CYC(2), .HOLD_CYC(2))
      u_b (.CLK(clk), .RST(rst_v[1]), .cfg_if(if_b));
   ble_config_loader #(.DATA_SIZE(8), .STROBE_SIZE(16), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1))
      u_c (.CLK(clk), .RST(rst_v[2]), .cfg_if(if_c));

   assign if_a.START = start_v[0];  assign if_a.CFG_VALID = valid_v[0];  assign if_a.CFG_DATA = cfg_v[0];
   assign if_b.START = start_v[1];  assign if_b.CFG_VALID = valid_v[1];  assign if_b.CFG_DATA = cfg_v[1];
   assign if_c.START = start_v[2];  assign if_c.CFG_VALID = valid_v[2];  assign if_c.CFG_DATA = cfg_v[2];

   assign o_data[0] = 32'(if_a.DATA);  assign o_strobe[0] = 32'(if_a.STROBE);  assign o_ready[0] = 32'(if_a.CFG_READY);
   assign o_data[1] = 32'(if_b.DATA);  assign o_strobe[1] = 32'(if_b.STROBE);  assign o_ready[1] = 32'(if_b.CFG_READY);
   assign o_data[2] = 32'(if_c.DATA);  assign o_strobe[2] = 32'(if_c.STROBE);  assign o_ready[2] = 32'(if_c.CFG_READY);
   assign o_busy[0] = 32'(if_a.BUSY);  assign o_done[0] = 32'(if_a.DONE);
   assign o_busy[1] = 32'(if_b.BUSY);  assign o_done[1] = 32'(if_b.DONE);
   assign o_busy[2] = 32'(if_c.BUSY);  assign o_done[2] = 32'(if_c.DONE);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (if_a.DONE) done_cnt_a++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input int s, input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (dut %0d): observed %0h expected %0h", tag, s, obs, exp);
      end
   endtask

   task automatic begin_pass(input int s);
      chk(s, "idle_busy", o_busy[s], 0);
      start_v[s] = 1'b1;
      tick();
      start_v[s] = 1'b0;
      chk(s, "load_busy", o_busy[s], 1);
      chk(s, "load_ready", o_ready[s], 1);
   endtask

   // Entered in a LOAD cycle; leaves on the cycle after the last HOLD cycle.
   task automatic do_word(input int s, input logic [7:0] din, input logic [31:0] exp_d,
                          input logic [31:0] exp_m, input int sc, input int pc, input int hc,
                          input int gap, input bit poke_start, output int hs);
      valid_v[s] = 1'b0;
      for (int i = 0; i < gap; i++) begin
         chk(s, "gap_ready", o_ready[s], 1);
         chk(s, "gap_strobe", o_strobe[s], 0);
         tick();
      end
      valid_v[s] = 1'b1;
      cfg_v[s]   = din;
      chk(s, "hs_ready", o_ready[s], 1);
      hs = cyc;
      tick();
      valid_v[s] = 1'b0;
      cfg_v[s]   = ~din;
      for (int i = 0; i < sc; i++) begin
         chk(s, "setup_ready", o_ready[s], 0);
         chk(s, "setup_strobe", o_strobe[s], 0);
         chk(s, "setup_data", o_data[s], exp_d);
         tick();
      end
      for (int i = 0; i < pc; i++) begin
         chk(s, "pulse_strobe", o_strobe[s], exp_m);
         chk(s, "pulse_data", o_data[s], exp_d);
         if (poke_start) start_v[s] = 1'b1;
         tick();
         start_v[s] = 1'b0;
      end
      for (int i = 0; i < hc; i++) begin
         chk(s, "hold_strobe", o_strobe[s], 0);
         chk(s, "hold_data", o_data[s], exp_d);
         chk(s, "hold_busy", o_busy[s], 1);
         tick();
      end
   endtask

   // Entered in the FINISH cycle.
   task automatic fin(input int s, input int hs0, input int lat);
      chk(s, "finish_done", o_done[s], 0);
      chk(s, "finish_busy", o_busy[s], 1);
      tick();
      chk(s, "done_pulse", o_done[s], 1);
      chk(s, "done_busy", o_busy[s], 0);
      chk(s, "done_data", o_data[s], 0);
      chk(s, "done_strobe", o_strobe[s], 0);
      chk(s, "done_ready", o_ready[s], 0);
      chk(s, "pass_latency", 32'(cyc - hs0), 32'(lat));
      tick();
      chk(s, "done_width", o_done[s], 0);
   endtask

   initial begin
      rst_v   = 3'b111;
      start_v = '0;
      valid_v = '0;
      for (int i = 0; i < 3; i++) cfg_v[i] = '0;
      tick();
      tick();
      rst_v = '0;

      // Reset values
      chk(0, "rst_data", o_data[0], 0);
      chk(0, "rst_strobe", o_strobe[0], 0);
      chk(0, "rst_ready", o_ready[0], 0);
      chk(0, "rst_busy", o_busy[0], 0);
      chk(0, "rst_done", o_done[0], 0);
      chk(1, "rst_busy", o_busy[1], 0);
      chk(2, "rst_strobe", o_strobe[2], 0);

      // Valid data in IDLE is not consumed
      valid_v[0] = 1'b1;
      cfg_v[0]   = 8'hAA;
      tick();
      tick();
      chk(0, "idle_ready", o_ready[0], 0);
      chk(0, "idle_data", o_data[0], 0);
      valid_v[0] = 1'b0;

      // Default pass: three words, last one masked to a single cell
      begin_pass(0);
      do_word(0, 8'hA5, 32'hA5, 32'h000FF, 1, 1, 1, 0, 1'b0, h0);
      do_word(0, 8'h3C, 32'h3C, 32'h0FF00, 1, 1, 1, 0, 1'b0, h1);
      do_word(0, 8'hFF, 32'h01, 32'h10000, 1, 1, 1, 0, 1'b0, h2);
      chk(0, "word_period", 32'(h1 - h0), 4);
      fin(0, h0, 13);

      // Five idle LOAD cycles before word 1
      begin_pass(0);
      do_word(0, 8'h12, 32'h12, 32'h000FF, 1, 1, 1, 0, 1'b0, h0);
      do_word(0, 8'h5A, 32'h5A, 32'h0FF00, 1, 1, 1, 5, 1'b0, h1);
      do_word(0, 8'hFE, 32'h00, 32'h10000, 1, 1, 1, 0, 1'b0, h2);
      fin(0, h0, 18);

      // START during word 1 PULSE must not restart or add a DONE
      dc = done_cnt_a;
      begin_pass(0);
      do_word(0, 8'h81, 32'h81, 32'h000FF, 1, 1, 1, 0, 1'b0, h0);
      do_word(0, 8'h7E, 32'h7E, 32'h0FF00, 1, 1, 1, 0, 1'b1, h1);
      do_word(0, 8'h03, 32'h01, 32'h10000, 1, 1, 1, 0, 1'b0, h2);
      fin(0, h0, 13);
      tick();
      tick();
      chk(0, "restart_busy", o_busy[0], 0);
      chk(0, "single_done", 32'(done_cnt_a - dc), 1);

      // Reset during word 1 PULSE
      begin_pass(0);
      do_word(0, 8'hC3, 32'hC3, 32'h000FF, 1, 1, 1, 0, 1'b0, h0);
      valid_v[0] = 1'b1;
      cfg_v[0]   = 8'h77;
      tick();
      valid_v[0] = 1'b0;
      tick();
      chk(0, "pre_rst_strobe", o_strobe[0], 32'h0FF00);
      dc = done_cnt_a;
      rst_v[0] = 1'b1;
      tick();
      rst_v[0] = 1'b0;
      chk(0, "mid_rst_strobe", o_strobe[0], 0);
      chk(0, "mid_rst_data", o_data[0], 0);
      chk(0, "mid_rst_busy", o_busy[0], 0);
      chk(0, "mid_rst_ready", o_ready[0], 0);
      tick();
      tick();
      tick();
      chk(0, "mid_rst_no_done", 32'(done_cnt_a - dc), 0);
      begin_pass(0);
      do_word(0, 8'h11, 32'h11, 32'h000FF, 1, 1, 1, 0, 1'b0, h0);
      do_word(0, 8'h22, 32'h22, 32'h0FF00, 1, 1, 1, 0, 1'b0, h1);
      do_word(0, 8'h33, 32'h01, 32'h10000, 1, 1, 1, 0, 1'b0, h2);
      fin(0, h0, 13);

      // Stretched timing: setup 3, pulse 2, hold 2
      begin_pass(1);
      do_word(1, 8'hA5, 32'hA5, 32'h000FF, 3, 2, 2, 0, 1'b0, h0);
      do_word(1, 8'h3C, 32'h3C, 32'h0FF00, 3, 2, 2, 0, 1'b0, h1);
      do_word(1, 8'hFF, 32'h01, 32'h10000, 3, 2, 2, 0, 1'b0, h2);
      chk(1, "word_period", 32'(h1 - h0), 8);
      chk(1, "word_period2", 32'(h2 - h1), 8);
      fin(1, h0, 25);

      // 16-cell element: no partial word, full DATA width
      begin_pass(2);
      do_word(2, 8'hC3, 32'hC3, 32'h00FF, 1, 1, 1, 0, 1'b0, h0);
      do_word(2, 8'h81, 32'h81, 32'hFF00, 1, 1, 1, 0, 1'b0, h1);
      fin(2, h0, 9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
